decode_stage: RTL and testbench
===============================

# decode_stage

Y86-64 pipelined decode stage: the read-side client of the register file. Holds the D pipeline register and derives `srcA`/`srcB`/`dstE`/`dstM` from the fetched instruction. It drives the register file read addresses, takes back `valA`/`valB`, and applies forwarding from the E/M/W stages. Results are latched into the E pipeline register for execute.

## Interface
Parameters:
- `RNONE`, 4'hF, "no register" ID
- `RRSP`, 4'h4, stack pointer ID
- `SAOK`, 3'd1, stat code used for bubbles and reset

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge
- `f_stat`, `f_icode`, `f_ifun`, `f_rA`, `f_rB`  in  3/4/4/4/4  fetch outputs
- `f_valC`, `f_valP`  in  64/64  constant word, next PC
- `D_stall`, `D_bubble`, `E_bubble`  in  1 each  hazard-unit controls
- `srcA`, `srcB`  out  4/4  register file read addresses (combinational)
- `rf_valA`, `rf_valB`  in  64/64  register file read data (combinational return)
- `e_dstE`, `e_valE`  in  4/64  execute-stage result, current cycle
- `M_dstM`, `m_valM`  in  4/64  memory load result
- `M_dstE`, `M_valE`  in  4/64  M-register ALU result
- `W_dstM`, `W_valM`, `W_dstE`, `W_valE`  in  4/64 each  writeback values
- `D_icode`  out  4  D-register icode, for the hazard unit
- `E_stat`, `E_icode`, `E_ifun`  out  3/4/4  E pipeline register
- `E_valC`, `E_valA`, `E_valB`  out  64 each
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`  out  4 each

## Operation
- **Decode**, combinational from the D register:
  - `srcA` = `rA` for icode 2, 4, 6, A; `RRSP` for 9, B; else `RNONE`.
  - `srcB` = `rB` for 4, 5, 6; `RRSP` for 8, 9, A, B; else `RNONE`.
  - `d_dstE` = `rB` for 2, 3, 6; `RRSP` for 8, 9, A, B; else `RNONE`.
  - `d_dstM` = `rA` for 5, B; else `RNONE`.
  - cmov `dstE` cancellation happens in execute, not here.
- **`d_valA` priority**, first match wins:
  1. icode 7 or 8 → `D_valP`
  2. `srcA==e_dstE` → `e_valE`
  3. `==M_dstM` → `m_valM`
  4. `==M_dstE` → `M_valE`
  5. `==W_dstM` → `W_valM`
  6. `==W_dstE` → `W_valE`
  7. otherwise `rf_valA`
- **`d_valB`**: same chain on `srcB`, without the valP term.
- **Forwarding suppression**: no forwarding match is taken when the source is `RNONE`, even if a stage dst is also `RNONE`. The raw register file value is used in that case.
- **D register update** at each posedge, in priority order:
  1. reset
  2. `D_stall` holds all fields
  3. `D_bubble` loads a nop
  4. otherwise load the `f_*` fields
- **D bubble/nop contents**: stat=`SAOK`, icode=1, ifun=0, rA=rB=`RNONE`, valC=valP=0.
- **E register update** at each posedge:
  1. reset loads a nop
  2. `E_bubble` loads a nop
  3. otherwise load the decode outputs
- **E nop contents**: stat=`SAOK`, icode=1, ifun=0, dst/src fields `RNONE`, values 0.
- Stat and icode/ifun are passed through unchanged. Invalid icodes (C–F) decode as `RNONE` everywhere.

## Timing
- Reset, synchronous on `rst_n` low:
  - D holds a nop; E outputs are `E_stat`=1, `E_icode`=1, `E_ifun`=0, `E_val*`=0, `E_dst*`/`E_src*`=F.
  - `srcA`/`srcB` are F from the first post-reset edge.
  - Reset overrides stall and bubble, and also aborts any in-flight instruction.
- Latency: an instruction latched into D at edge n appears on the E outputs at edge n+1 (absent stall/bubble).
- `srcA`, `srcB`, `d_valA`, `d_valB`, `D_icode` are purely combinational within the cycle.
- The register file writes on posedge, so a same-cycle W write is not yet visible on `rf_val*`. W forwarding covers that case.
- When `D_stall` and `D_bubble` are both high, stall wins.
- A load/use hazard is resolved externally: the hazard unit asserts `D_stall` together with `E_bubble`. The block does not detect it.
- No output depends on reset asynchronously.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with garbage `f_*` → E outputs are nop/`F` values and `srcA`=`srcB`=F.
- **No-hazard OPq** (icode 6, rA=2, rB=3), `rf_valA`=10, `rf_valB`=20 → one cycle later `E_valA`=10, `E_valB`=20, `E_dstE`=3, `E_dstM`=F.
- **Forward priority:** srcA=2 with `e_dstE`=2/`e_valE`=0xAA, `M_dstE`=2/`M_valE`=0xBB, and `W_dstE`=2 → `E_valA`=0xAA. Then remove the e match → 0xBB.
- **popq** (icode B, rA=5) → `srcA`=`srcB`=4, `E_dstE`=4, `E_dstM`=5. **call** (icode 8) with `f_valP`=0x123 → `E_valA`=0x123.
- **Stall/bubble:**
  - `D_stall`=1 for 2 cycles → D_icode held and E repeats the same decode.
  - `D_bubble`=1 → next E is a nop.
  - Both high → stall wins.
  - `E_bubble`=1 → E is a nop for that cycle.
- **RNONE guard:** irmovq (srcA=F) with `e_dstE`=F/`e_valE`=0x55 and `rf_valA`=0x77 → `E_valA`=0x77. Then assert `rst_n`=0 mid-stream → E returns to nop on the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register-source/destination decode,
// E/M/W forwarding onto valA/valB, and the E pipeline register.
module decode_stage #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [3:0] RRSP  = 4'h4,
   parameter logic [2:0] SAOK  = 3'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  f_stat,
   input  logic [3:0]  f_icode,
   input  logic [3:0]  f_ifun,
   input  logic [3:0]  f_rA,
   input  logic [3:0]  f_rB,
   input  logic [63:0] f_valC,
   input  logic [63:0] f_valP,
   input  logic        D_stall,
   input  logic        D_bubble,
   input  logic        E_bubble,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   input  logic [63:0] rf_valA,
   input  logic [63:0] rf_valB,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] m_valM,
   input  logic [3:0]  M_dstE,
   input  logic [63:0] M_valE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valM,
   input  logic [3:0]  W_dstE,
   input  logic [63:0] W_valE,
   output logic [3:0]  D_icode,
   output logic [2:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB
);

   logic [2:0]  D_stat_q;
   logic [3:0]  D_icode_q, D_ifun_q, D_rA_q, D_rB_q;
   logic [63:0] D_valC_q, D_valP_q;

   logic [3:0]  d_dstE, d_dstM;
   logic [63:0] d_valA, d_valB;

   always_ff @(posedge clk) begin
      if (!rst_n || (D_bubble && !D_stall)) begin
         D_stat_q  <= SAOK;
         D_icode_q <= 4'h1;
         D_ifun_q  <= '0;
         D_rA_q    <= RNONE;
         D_rB_q    <= RNONE;
         D_valC_q  <= '0;
         D_valP_q  <= '0;
      end else if (!D_stall) begin
         D_stat_q  <= f_stat;
         D_icode_q <= f_icode;
         D_ifun_q  <= f_ifun;
         D_rA_q    <= f_rA;
         D_rB_q    <= f_rB;
         D_valC_q  <= f_valC;
         D_valP_q  <= f_valP;
      end
   end

   assign D_icode = D_icode_q;

   always_comb begin
      srcA   = RNONE;
      srcB   = RNONE;
      d_dstE = RNONE;
      d_dstM = RNONE;
      case (D_icode_q)
         4'h2: begin srcA = D_rA_q;                    d_dstE = D_rB_q; end
         4'h3: begin                                   d_dstE = D_rB_q; end
         4'h4: begin srcA = D_rA_q; srcB = D_rB_q;                      end
         4'h5: begin                srcB = D_rB_q;     d_dstM = D_rA_q; end
         4'h6: begin srcA = D_rA_q; srcB = D_rB_q;     d_dstE = D_rB_q; end
         4'h8: begin                srcB = RRSP;       d_dstE = RRSP;   end
         4'h9: begin srcA = RRSP;   srcB = RRSP;       d_dstE = RRSP;   end
         4'hA: begin srcA = D_rA_q; srcB = RRSP;       d_dstE = RRSP;   end
         4'hB: begin srcA = RRSP;   srcB = RRSP;       d_dstE = RRSP;
                     d_dstM = D_rA_q;                                   end
         default: ;
      endcase
   end

   // RNONE source never forwards, even against a stage whose dst is also RNONE
   function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
      if (src == RNONE)        return rf;
      else if (src == e_dstE)  return e_valE;
      else if (src == M_dstM)  return m_valM;
      else if (src == M_dstE)  return M_valE;
      else if (src == W_dstM)  return W_valM;
      else if (src == W_dstE)  return W_valE;
      else                     return rf;
   endfunction

   always_comb begin
      d_valA = fwd(srcA, rf_valA);
      if (D_icode_q == 4'h7 || D_icode_q == 4'h8) d_valA = D_valP_q;
      d_valB = fwd(srcB, rf_valB);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || E_bubble) begin
         E_stat  <= SAOK;
         E_icode <= 4'h1;
         E_ifun  <= '0;
         E_valC  <= '0;
         E_valA  <= '0;
         E_valB  <= '0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
      end else begin
         E_stat  <= D_stat_q;
         E_icode <= D_icode_q;
         E_ifun  <= D_ifun_q;
         E_valC  <= D_valC_q;
         E_valA  <= d_valA;
         E_valB  <= d_valB;
         E_dstE  <= d_dstE;
         E_dstM  <= d_dstM;
         E_srcA  <= srcA;
         E_srcB  <= srcB;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: expectations are queued per cycle and
// a monitor compares them against the DUT just after each rising edge.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  f_stat;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
   logic [63:0] f_valC, f_valP;
   logic        D_stall, D_bubble, E_bubble;
   logic [3:0]  srcA, srcB;
   logic [63:0] rf_valA, rf_valB;
   logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
   logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
   logic [3:0]  D_icode;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode, E_ifun;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

   decode_stage #(.RNONE(4'hF), .RRSP(4'h4), .SAOK(3'd1)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
      .f_valC(f_valC), .f_valP(f_valP),
      .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .srcA(srcA), .srcB(srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
      .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
      .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_valE(W_valE),
      .D_icode(D_icode), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          at;
      string       tag;
      bit          isE;
      logic [2:0]  stat;
      logic [3:0]  icode, ifun;
      logic [63:0] valC, valA, valB;
      logic [3:0]  dstE, dstM, sA, sB;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [3:0] F = 4'hF;

   task automatic expE(input int at, input string tag, input logic [2:0] stat,
                       input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valC,
                       input logic [63:0] valA, input logic [63:0] valB,
                       input logic [3:0] dstE, input logic [3:0] dstM,
                       input logic [3:0] sA, input logic [3:0] sB);
      exp_t e;
      e.at = at; e.tag = tag; e.isE = 1'b1; e.stat = stat; e.icode = icode; e.ifun = ifun;
      e.valC = valC; e.valA = valA; e.valB = valB; e.dstE = dstE; e.dstM = dstM;
      e.sA = sA; e.sB = sB;
      q.push_back(e);
   endtask

   task automatic expNop(input int at, input string tag);
      expE(at, tag, 3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F);
   endtask

   task automatic expD(input int at, input string tag, input logic [3:0] sA,
                       input logic [3:0] sB, input logic [3:0] icode);
      exp_t e;
      e.at = at; e.tag = tag; e.isE = 1'b0; e.stat = '0; e.icode = icode; e.ifun = '0;
      e.valC = '0; e.valA = '0; e.valB = '0; e.dstE = '0; e.dstM = '0;
      e.sA = sA; e.sB = sB;
      q.push_back(e);
   endtask

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check(input exp_t e);
      if (e.isE) begin
         cmp({e.tag, ".E_stat"},  64'(E_stat),  64'(e.stat));
         cmp({e.tag, ".E_icode"}, 64'(E_icode), 64'(e.icode));
         cmp({e.tag, ".E_ifun"},  64'(E_ifun),  64'(e.ifun));
         cmp({e.tag, ".E_valC"},  E_valC,       e.valC);
         cmp({e.tag, ".E_valA"},  E_valA,       e.valA);
         cmp({e.tag, ".E_valB"},  E_valB,       e.valB);
         cmp({e.tag, ".E_dstE"},  64'(E_dstE),  64'(e.dstE));
         cmp({e.tag, ".E_dstM"},  64'(E_dstM),  64'(e.dstM));
         cmp({e.tag, ".E_srcA"},  64'(E_srcA),  64'(e.sA));
         cmp({e.tag, ".E_srcB"},  64'(E_srcB),  64'(e.sB));
      end else begin
         cmp({e.tag, ".srcA"},    64'(srcA),    64'(e.sA));
         cmp({e.tag, ".srcB"},    64'(srcB),    64'(e.sB));
         cmp({e.tag, ".D_icode"}, 64'(D_icode), 64'(e.icode));
      end
   endtask

   // Monitor: E/D state is presented every cycle; compare whatever is due now.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at < cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL %s: missed check slot %0d at cycle %0d", e.tag, e.at, cyc);
            end else begin
               check(e);
            end
         end
      end
   end

   task automatic fetch(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
      f_stat = st; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
   endtask

   task automatic fwd_clear();
      e_dstE = F; M_dstM = F; M_dstE = F; W_dstM = F; W_dstE = F;
      e_valE = 64'hE0E0; m_valM = 64'h66; M_valE = 64'hA0A0; W_valM = 64'hB0B0; W_valE = 64'hC0C0;
      rf_valA = '0; rf_valB = '0;
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0; E_bubble = 1'b0;
      fwd_clear();
      fetch(3'd5, 4'h6, 4'h3, 4'h2, 4'h3, 64'hDEAD, 64'hBEEF);
      expNop(2, "rst_E");
      expD(2, "rst_D", F, F, 4'h1);
      next_cyc();
      next_cyc();

      rst_n = 1'b1;
      fetch(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h1111, 64'h10);
      expNop(cyc + 1, "post_rst_E");
      expD(cyc + 1, "opq_D", 4'h2, 4'h3, 4'h6);
      next_cyc();

      rf_valA = 64'd10; rf_valB = 64'd20;
      fetch(3'd1, 4'h6, 4'h1, 4'h2, 4'h7, 64'h0, 64'h20);
      expE(cyc + 1, "opq_E", 3'd1, 4'h6, 4'h0, 64'h1111, 64'd10, 64'd20, 4'h3, F, 4'h2, 4'h3);
      expD(cyc + 1, "fwd_D", 4'h2, 4'h7, 4'h6);
      next_cyc();

      rf_valA = 64'h11; rf_valB = 64'h22;
      e_dstE = 4'h2; e_valE = 64'hAA;
      M_dstE = 4'h2; M_valE = 64'hBB;
      W_dstE = 4'h2; W_valE = 64'hCC;
      expE(cyc + 1, "fwd_e", 3'd1, 4'h6, 4'h1, 64'h0, 64'hAA, 64'h22, 4'h7, F, 4'h2, 4'h7);
      expD(cyc + 1, "fwd2_D", 4'h2, 4'h7, 4'h6);
      next_cyc();

      e_dstE = F; W_dstM = 4'h7; W_valM = 64'h77;
      fetch(3'd2, 4'hB, 4'h0, 4'h5, F, 64'h0, 64'h30);
      expE(cyc + 1, "fwd_M", 3'd1, 4'h6, 4'h1, 64'h0, 64'hBB, 64'h77, 4'h7, F, 4'h2, 4'h7);
      expD(cyc + 1, "popq_D", 4'h4, 4'h4, 4'hB);
      next_cyc();

      fwd_clear();
      rf_valA = 64'h5A; rf_valB = 64'h5B;
      fetch(3'd1, 4'h8, 4'h0, F, F, 64'h400, 64'h123);
      expE(cyc + 1, "popq_E", 3'd2, 4'hB, 4'h0, 64'h0, 64'h5A, 64'h5B, 4'h4, 4'h5, 4'h4, 4'h4);
      expD(cyc + 1, "call_D", F, 4'h4, 4'h8);
      next_cyc();

      rf_valA = 64'h99; rf_valB = 64'h40;
      e_dstE = 4'h4; e_valE = 64'h3C;
      fetch(3'd1, 4'h6, 4'h2, 4'h1, 4'h2, 64'h0, 64'h0);
      expE(cyc + 1, "call_E", 3'd1, 4'h8, 4'h0, 64'h400, 64'h123, 64'h3C, 4'h4, F, F, 4'h4);
      expD(cyc + 1, "stl_D0", 4'h1, 4'h2, 4'h6);
      next_cyc();

      fwd_clear();
      rf_valA = 64'd1; rf_valB = 64'd2;
      D_stall = 1'b1;
      fetch(3'd1, 4'h3, 4'h0, F, 4'h9, 64'h55, 64'h60);
      expE(cyc + 1, "stall1", 3'd1, 4'h6, 4'h2, 64'h0, 64'd1, 64'd2, 4'h2, F, 4'h1, 4'h2);
      expD(cyc + 1, "stall1_D", 4'h1, 4'h2, 4'h6);
      next_cyc();

      expE(cyc + 1, "stall2", 3'd1, 4'h6, 4'h2, 64'h0, 64'd1, 64'd2, 4'h2, F, 4'h1, 4'h2);
      expD(cyc + 1, "stall2_D", 4'h1, 4'h2, 4'h6);
      next_cyc();

      D_bubble = 1'b1;
      expE(cyc + 1, "stall_win", 3'd1, 4'h6, 4'h2, 64'h0, 64'd1, 64'd2, 4'h2, F, 4'h1, 4'h2);
      expD(cyc + 1, "stall_win_D", 4'h1, 4'h2, 4'h6);
      next_cyc();

      D_stall = 1'b0;
      expE(cyc + 1, "pre_bub", 3'd1, 4'h6, 4'h2, 64'h0, 64'd1, 64'd2, 4'h2, F, 4'h1, 4'h2);
      expD(cyc + 1, "dbub_D", F, F, 4'h1);
      next_cyc();

      D_bubble = 1'b0;
      rf_valA = '0; rf_valB = '0;
      expNop(cyc + 1, "dbub_E");
      expD(cyc + 1, "irm_D", F, F, 4'h3);
      next_cyc();

      E_bubble = 1'b1; D_stall = 1'b1;
      expNop(cyc + 1, "ebub_E");
      expD(cyc + 1, "ebub_D", F, F, 4'h3);
      next_cyc();

      E_bubble = 1'b0; D_stall = 1'b0;
      e_valE = 64'h55; rf_valA = 64'h77;
      fetch(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'hABC, 64'h0);
      expE(cyc + 1, "rnone", 3'd1, 4'h3, 4'h0, 64'h55, 64'h77, 64'h0, 4'h9, F, F, F);
      expD(cyc + 1, "pre_rst_D", 4'h2, 4'h3, 4'h6);
      next_cyc();

      rst_n = 1'b0; D_stall = 1'b1;
      expNop(cyc + 1, "midrst_E");
      expD(cyc + 1, "midrst_D", F, F, 4'h1);
      next_cyc();

      rst_n = 1'b1; D_stall = 1'b0;
      fetch(3'd1, 4'h1, 4'h0, F, F, 64'h0, 64'h0);
      rf_valA = '0; rf_valB = '0;

      for (int i = 0; i < 10 && q.size() > 0; i++) next_cyc();
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations never checked (want 0)", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
